// File: rtl/rfi_corr_readout_pkg.sv
// Shared definitions for the rfi_corr_readout block.
//   rd_state_t      : read-bank ownership states
//   ram_addr_width  : RAM address width (one bank-select bit above the channel index)
package rfi_corr_readout_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } rd_state_t;

  function automatic int ram_addr_width(input int channel_addr);
    return channel_addr + 1;
  endfunction

endpackage

// File: rtl/rfi_corr_readout_bram_sdp.sv
// Simple dual-port block RAM: one write port, one registered read port.
// Contents are not reset.
// Ports:
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   re     in  read enable; rdata updates on the following edge
//   raddr  in  read address
//   rdata  out registered read data
module rfi_corr_readout_bram_sdp #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/rfi_corr_readout.sv
// Reader side of the rfi_correlation output stream. Each complete frame
// (one sample per channel) is captured into a ping-pong RAM; the held frame
// is read back by channel address with 2-cycle latency.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_EMPTY | read bank free; next complete frame is delivered
// ST_HELD  | read bank holds an unacknowledged frame; new frames drop
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   din, din_valid            power samples in channel order
//   din_warning               correlator overflow flag, sampled with din_valid
//   cnt_rst                   sync realign of channel counter (drops partial frame)
//   rd_addr, rd_en            read request on the held frame
//   rd_data, rd_valid         read response, 2 cycles after rd_en
//   frame_ready, frame_ack    held-frame handshake
//   frame_warning             held frame contained a warning sample
//   frame_count, drop_count   delivered / dropped frame counters (wrap)
//   overrun                   sticky, set on first dropped frame
module rfi_corr_readout
  import rfi_corr_readout_pkg::*;
#(
  parameter int DIN_WIDTH    = 16,
  parameter int CHANNEL_ADDR = 9,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DIN_WIDTH-1:0]    din,
  input  logic                    din_valid,
  input  logic                    din_warning,
  input  logic                    cnt_rst,
  input  logic [CHANNEL_ADDR-1:0] rd_addr,
  input  logic                    rd_en,
  output logic [DIN_WIDTH-1:0]    rd_data,
  output logic                    rd_valid,
  output logic                    frame_ready,
  input  logic                    frame_ack,
  output logic                    frame_warning,
  output logic [CNT_WIDTH-1:0]    frame_count,
  output logic [CNT_WIDTH-1:0]    drop_count,
  output logic                    overrun
);

  localparam int RAM_AW = ram_addr_width(CHANNEL_ADDR);
  localparam logic [CHANNEL_ADDR-1:0] LAST_CHAN = '1;

  rd_state_t               state, state_nxt;
  logic [CHANNEL_ADDR-1:0] chan;
  logic                    warn_acc;
  logic                    wr_bank, rd_bank;
  logic                    wr_en, complete, swap, drop;
  logic                    rd_en_q;
  logic [DIN_WIDTH-1:0]    ram_rdata;

  // cnt_rst takes priority over a coincident sample
  assign wr_en       = din_valid & ~cnt_rst;
  assign complete    = wr_en & (chan == LAST_CHAN);
  assign frame_ready = (state == ST_HELD);

  always_comb begin
    state_nxt = state;
    swap      = 1'b0;
    drop      = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (complete) begin
          swap      = 1'b1;
          state_nxt = ST_HELD;
        end
      end
      ST_HELD: begin
        // An ack coinciding with a completion is honoured first, so the
        // new frame is swapped in rather than dropped.
        if (frame_ack) begin
          if (complete) swap = 1'b1;
          else          state_nxt = ST_EMPTY;
        end else if (complete) begin
          drop = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_EMPTY;
      chan          <= '0;
      warn_acc      <= 1'b0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      frame_warning <= 1'b0;
      frame_count   <= '0;
      drop_count    <= '0;
      overrun       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cnt_rst) begin
        chan     <= '0;
        warn_acc <= 1'b0;
      end else if (din_valid) begin
        chan     <= chan + CHANNEL_ADDR'(1);
        warn_acc <= complete ? 1'b0 : (warn_acc | din_warning);
      end
      if (swap) begin
        rd_bank       <= wr_bank;
        wr_bank       <= ~wr_bank;
        frame_warning <= warn_acc | din_warning;
        frame_count   <= frame_count + CNT_WIDTH'(1);
      end
      // On a drop wr_bank stays put so the next frame overwrites the dropped one.
      if (drop) begin
        drop_count <= drop_count + CNT_WIDTH'(1);
        overrun    <= 1'b1;
      end
    end
  end

  rfi_corr_readout_bram_sdp #(
    .DATA_WIDTH (DIN_WIDTH),
    .ADDR_WIDTH (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({wr_bank, chan}),
    .wdata (din),
    .re    (rd_en),
    .raddr ({rd_bank, rd_addr}),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en_q  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_en_q  <= rd_en;
      rd_valid <= rd_en_q;
      if (rd_en_q) rd_data <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_rfi_corr_readout.sv
// Self-checking bench for rfi_corr_readout with 8 channels.
module tb_rfi_corr_readout;

  localparam int DW = 16;
  localparam int CA = 3;
  localparam int CW = 32;
  localparam int NCH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          din_warning = 1'b0;
  logic          cnt_rst = 1'b0;
  logic [CA-1:0] rd_addr = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          frame_ready;
  logic          frame_ack = 1'b0;
  logic          frame_warning;
  logic [CW-1:0] frame_count;
  logic [CW-1:0] drop_count;
  logic          overrun;

  int n_cmp = 0;
  int n_err = 0;

  rfi_corr_readout #(.DIN_WIDTH(DW), .CHANNEL_ADDR(CA), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_warning(din_warning),
    .cnt_rst(cnt_rst), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .frame_ready(frame_ready), .frame_ack(frame_ack),
    .frame_warning(frame_warning), .frame_count(frame_count), .drop_count(drop_count),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: collects samples, delivers or drops whole frames.
  logic [DW-1:0] m_cur [NCH];
  logic [DW-1:0] m_held [NCH];
  int            m_chan = 0;
  bit            m_warn = 0;
  bit            m_ready = 0;
  bit            m_fwarn = 0;
  bit            m_overrun = 0;
  int unsigned   m_fcount = 0;
  int unsigned   m_dcount = 0;
  bit            pv1 = 0, pv2 = 0;
  logic [DW-1:0] pd1 = '0, pd2 = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_chan = 0; m_warn = 0; m_ready = 0; m_fwarn = 0; m_overrun = 0;
      m_fcount = 0; m_dcount = 0; pv1 = 0; pv2 = 0; pd1 = '0; pd2 = '0;
    end else begin
      bit done;
      done = 0;
      pv2 = pv1; pd2 = pd1;
      pv1 = rd_en;
      pd1 = m_held[rd_addr];
      if (cnt_rst) begin
        m_chan = 0; m_warn = 0;
      end else if (din_valid) begin
        m_cur[m_chan] = din;
        m_warn = m_warn | din_warning;
        if (m_chan == NCH - 1) done = 1;
        else m_chan++;
      end
      if (frame_ack && m_ready) m_ready = 0;
      if (done) begin
        if (!m_ready) begin
          m_held = m_cur;
          m_ready = 1;
          m_fwarn = m_warn;
          m_fcount++;
        end else begin
          m_dcount++;
          m_overrun = 1;
        end
        m_chan = 0; m_warn = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("frame_ready", 32'(frame_ready), 32'(m_ready));
      chk("frame_warning", 32'(frame_warning), 32'(m_fwarn));
      chk("frame_count", frame_count, m_fcount);
      chk("drop_count", drop_count, m_dcount);
      chk("overrun", 32'(overrun), 32'(m_overrun));
      chk("rd_valid", 32'(rd_valid), 32'(pv2));
      if (pv2) chk("rd_data", 32'(rd_data), 32'(pd2));
    end
  end

  task automatic send_frame(input int base, input int gap, input int warn_ch, input bit ack_last);
    for (int i = 0; i < NCH; i++) begin
      din = DW'(base + i);
      din_valid = 1'b1;
      din_warning = (i == warn_ch);
      frame_ack = ack_last && (i == NCH - 1);
      @(negedge clk);
      din_valid = 1'b0;
      din_warning = 1'b0;
      frame_ack = 1'b0;
      for (int g = 0; g < gap && i < NCH - 1; g++) @(negedge clk);
    end
  endtask

  task automatic ack_pulse();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < NCH; i++) begin
      rd_en = 1'b1;
      rd_addr = CA'(i);
      @(negedge clk);
    end
    rd_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic read_one(input int addr, input int exp);
    int lat;
    rd_en = 1'b1;
    rd_addr = CA'(addr);
    @(negedge clk);
    rd_en = 1'b0;
    lat = 1;
    while (!rd_valid && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    chk("read_latency", lat, 2);
    chk("read_literal", 32'(rd_data), exp);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(frame_ready), 0);
    chk("reset_fcount", frame_count, 0);

    // 1: first frame delivered
    send_frame(0, 0, -1, 0);
    chk("t1_ready", 32'(frame_ready), 1);
    chk("t1_fcount", frame_count, 1);
    read_all();
    read_one(5, 5);

    // 2: overrun while held
    send_frame(100, 0, -1, 0);
    chk("t2_overrun", 32'(overrun), 1);
    chk("t2_dcount", drop_count, 1);
    read_all();
    read_one(2, 2);

    // 3: ack coincides with completion
    send_frame(200, 0, -1, 1);
    chk("t3_ready", 32'(frame_ready), 1);
    chk("t3_dcount", drop_count, 1);
    chk("t3_fcount", frame_count, 2);
    read_all();
    read_one(7, 207);

    // 4: gapped input
    ack_pulse();
    chk("t4_ack_ready", 32'(frame_ready), 0);
    send_frame(10, 2, -1, 0);
    chk("t4_fcount", frame_count, 3);
    read_all();
    read_one(4, 14);

    // 5: warning frame then clean frame
    ack_pulse();
    send_frame(30, 0, 5, 0);
    chk("t5_warn", 32'(frame_warning), 1);
    ack_pulse();
    send_frame(40, 0, -1, 0);
    chk("t5_clean", 32'(frame_warning), 0);
    read_all();

    // 6: cnt_rst mid-frame (coincident sample discarded), then async reset
    ack_pulse();
    send_frame(50, 0, -1, 0);   // delivered, leaves frame 50..57 held
    ack_pulse();
    for (int i = 0; i < 4; i++) begin
      din = DW'(90 + i); din_valid = 1'b1;
      @(negedge clk);
    end
    din = 16'd99; cnt_rst = 1'b1;
    @(negedge clk);
    din_valid = 1'b0; cnt_rst = 1'b0;
    send_frame(20, 0, -1, 0);
    chk("t6_fcount", frame_count, 7);
    read_all();
    read_one(0, 20);
    read_one(7, 27);

    rd_en = 1'b1; rd_addr = 3'd1;
    @(negedge clk);
    rd_en = 1'b0;
    @(posedge clk);
    #2;
    chk("pre_rst_valid", 32'(rd_valid), 1);
    rst = 1'b1;
    #1;
    chk("arst_ready", 32'(frame_ready), 0);
    chk("arst_fcount", frame_count, 0);
    chk("arst_overrun", 32'(overrun), 0);
    chk("arst_valid", 32'(rd_valid), 0);
    chk("arst_dcount", drop_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame(60, 1, -1, 0);
    chk("post_rst_fcount", frame_count, 1);
    read_all();
    read_one(3, 63);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
